div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants and state type for the multi-cycle EX-stage divider.
package div_unit_pkg;

  localparam int unsigned DataW = 32;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake: operands and request in, {remainder, quotient} and ready out.
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring 32-bit divider for MIPS DIV/DIVU: one quotient bit per clock,
// result_o = {remainder, quotient}, held with ready_o until EX drops start_i.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned CNT_W  = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave div_if
);

  div_state_e            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_W-1:0]     rem_q,    rem_d;
  logic [DATA_W-1:0]     quo_q,    quo_d;
  logic [DATA_W-1:0]     dvs_q,    dvs_d;
  logic                  neg1_q,   neg1_d;
  logic                  neg2_q,   neg2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q,  ready_d;

  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       trial, diff;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  // Datapath helpers: operand magnitudes, one restoring trial, final sign fix.
  // quo_q doubles as the dividend shift register: its msb feeds the trial and
  // the new quotient bit enters at the bottom. Sign flags are only set for DIV,
  // so DIVU never negates.
  always_comb begin
    op1_abs = (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1]) ? -div_if.opdata1_i
                                                                  : div_if.opdata1_i;
    op2_abs = (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1]) ? -div_if.opdata2_i
                                                                  : div_if.opdata2_i;
    trial   = {rem_q, quo_q[DATA_W-1]};
    diff    = trial - {1'b0, dvs_q};
    quo_fix = (neg1_q ^ neg2_q) ? -quo_q : quo_q;
    rem_fix = neg1_q ? -rem_q : rem_q;
  end

  // Next-state and registered-output logic for the IDLE/BYZERO/ON/END sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (div_if.start_i == DivStart && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            quo_d   = op1_abs;
            dvs_d   = op2_abs;
            neg1_d  = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
            neg2_d  = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
            cnt_d   = '0;
            rem_d   = '0;
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end

      DivOn: begin
        if (div_if.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          // trial < 2*divisor, so whichever value is kept fits in DATA_W bits
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        if (div_if.start_i == DivStop || div_if.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end

      default: begin
        state_d  = DivFree;
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  // State register with synchronous reset taking priority in every state.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (annul, reset mid-op, held start, operand churn) and random ops
// checked against a plain-arithmetic reference.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(W)) dif ();

  div_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // MIPS DIV/DIVU semantics: truncating division, remainder follows dividend;
  // divide by zero yields all zeros.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Inputs are already set with start high; the next rising edge is edge 0.
  task automatic wait_result(input string name, input logic [63:0] exp, input int exp_lat,
                             input int hold, input bit scramble);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    check_int({name, "/ready_after_accept"}, int'(dif.ready_o), 0);
    for (int e = 1; e <= 60; e++) begin
      if (scramble) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (dif.ready_o) begin
        lat = e;
        break;
      end
    end
    check_int({name, "/latency"}, lat, exp_lat);
    check64({name, "/result"}, dif.result_o, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_int({name, "/hold_ready"}, int'(dif.ready_o), 1);
      check64({name, "/hold_result"}, dif.result_o, exp);
    end
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check_int({name, "/drop_ready"}, int'(dif.ready_o), 0);
    check64({name, "/drop_result"}, dif.result_o, 64'd0);
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold, input bit scramble);
    @(negedge clk);
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    wait_result(name, exp, exp_lat, hold, scramble);
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb;
    int          seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 1};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
    vecs[5]  = '{1'b0, 32'd9,          32'd3,        64'h00000000_00000003, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 33};
    vecs[8]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 33};
    vecs[9]  = '{1'b0, 32'd3,          32'd5,        64'h00000003_00000000, 33};
    vecs[10] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 33};
    vecs[11] = '{1'b1, 32'h80000000,   32'd0,        64'h00000000_00000000, 1};
    vecs[12] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};

    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset/ready", int'(dif.ready_o), 0);
    check64("reset/result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             (i == 0) ? 0 : 1, 1'b0);
    end

    // Annul at iteration 10, then a fresh 9/3 two cycles later
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check_int("annul/ready", int'(dif.ready_o), 0);
    check64("annul/result", dif.result_o, 64'd0);
    @(negedge clk);
    dif.annul_i = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (dif.ready_o) seen++;
    end
    check_int("annul/ready_never", seen, 0);
    run_op("annul_restart", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0, 1'b0);

    // Reset at iteration 20 with start held across release
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst           = 1'b1;
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd5;
    @(posedge clk); #1;
    check_int("midrst/ready", int'(dif.ready_o), 0);
    check64("midrst/result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_result("midrst_restart", 64'h00000000_0000000A, 33, 0, 1'b0);

    // start and annul together in IDLE: nothing starts until annul drops
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd20;
    dif.opdata2_i    = 32'd4;
    dif.start_i      = 1'b1;
    dif.annul_i      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("start_annul/ready", int'(dif.ready_o), 0);
    @(negedge clk);
    dif.annul_i = 1'b0;
    wait_result("start_annul_go", 64'h00000000_00000005, 33, 0, 1'b0);

    // Operand churn during ON, start held 5 extra cycles in END (-1000 / 7)
    run_op("churn", 1'b1, 32'hFFFFFC18, 32'd7, 64'hFFFFFFFA_FFFFFF72, 33, 5, 1'b1);

    // Random operations against the reference
    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", k), rs, ra, rb, ref_div(rs, ra, rb),
             (rb == 32'd0) ? 1 : 33, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
